// File: rtl/boot_loader.sv
// Boot loader: streams a fixed-length program image from the BIOS capture
// source into instruction memory. It then checks a trailing checksum word.
// On a match it releases the core; on a mismatch or a stall it holds the core.
module boot_loader #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    BOOT_WORDS     = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              src_valid,
  input  logic [DATA_WIDTH-1:0]             src_data,
  output logic                              src_ready,
  output logic [ADDR_WIDTH-1:0]             mem_address,
  output logic [DATA_WIDTH-1:0]             mem_data,
  output logic                              mem_we,
  output logic                              core_enable,
  output logic                              done,
  output logic                              error,
  output logic [$clog2(BOOT_WORDS+1)-1:0]   words_loaded
);

  localparam int COUNT_WIDTH = $clog2(BOOT_WORDS + 1);
  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    RUN,
    ERROR
  } bootState_t;

  bootState_t                 state;
  bootState_t                 stateNext;
  logic [COUNT_WIDTH-1:0]     count;
  logic [DATA_WIDTH-1:0]      sum;
  logic [TIMER_WIDTH-1:0]     timer;
  logic [ADDR_WIDTH-1:0]      memAddressReg;
  logic [DATA_WIDTH-1:0]      memDataReg;
  logic                       memWeReg;

  logic accepting;
  logic transfer;
  logic lastWord;
  logic timeoutHit;
  logic restart;

  // The loader only takes words while loading data or waiting for the checksum.
  assign accepting  = (state == LOAD) || (state == CHECK);
  assign transfer   = accepting && src_valid;
  assign lastWord   = (count == COUNT_WIDTH'(BOOT_WORDS - 1));
  // A transfer on the expiry edge clears the timer, so it beats the timeout.
  assign timeoutHit = accepting && !transfer &&
                      (timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));
  assign restart    = start && ((state == IDLE) || (state == ERROR));

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments. Every register then
    // updates from values sampled before the edge, whatever the block order.
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: the default assignment comes first. Paths that do not change the
    // state then still assign it, so the decode infers no latch.
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (start) stateNext = LOAD;
      end
      LOAD: begin
        if (transfer && lastWord) stateNext = CHECK;
        else if (timeoutHit)      stateNext = ERROR;
      end
      CHECK: begin
        if (transfer)        stateNext = (src_data == sum) ? RUN : ERROR;
        else if (timeoutHit) stateNext = ERROR;
      end
      RUN: begin
        stateNext = RUN;
      end
      ERROR: begin
        if (start) stateNext = LOAD;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Word count, running checksum and stall timer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      sum   <= '0;
      timer <= '0;
    end else if (restart) begin
      count <= '0;
      sum   <= '0;
      timer <= '0;
    end else if (transfer) begin
      timer <= '0;
      if (state == LOAD) begin
        count <= count + COUNT_WIDTH'(1);
        sum   <= sum + src_data;
      end
    end else if (accepting) begin
      timer <= timer + TIMER_WIDTH'(1);
    end
  end

  // Memory write port: a one-cycle strobe per data word.
  // Address and data hold their last values between strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      memAddressReg <= '0;
      memDataReg    <= '0;
      memWeReg      <= 1'b0;
    end else begin
      memWeReg <= 1'b0;
      if (transfer && (state == LOAD)) begin
        memAddressReg <= BASE_ADDR + ADDR_WIDTH'(count);
        memDataReg    <= src_data;
        memWeReg      <= 1'b1;
      end
    end
  end

  // Outputs come only from registers or from a decode of the state register.
  assign src_ready    = accepting;
  assign core_enable  = (state == RUN);
  assign done         = (state == RUN);
  assign error        = (state == ERROR);
  assign mem_address  = memAddressReg;
  assign mem_data     = memDataReg;
  assign mem_we       = memWeReg;
  assign words_loaded = count;

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
Parametrised boot loader that sits between the BIOS capture source and the instruction memory's write port. It streams BOOT_WORDS program words into instruction memory at BASE_ADDR upward, then checks a trailing checksum word. On a match it releases the core; on a mismatch or timeout it holds the core in reset. It replaces the fixed-length, free-running address increment, gated by a BIOS-active flag, used in the first-generation top level.

Parameters:
DATA_WIDTH, 32, width of program words and checksum
ADDR_WIDTH, 32, instruction memory address width
BOOT_WORDS, 16, program words per boot image (>=1)
BASE_ADDR, 0, first instruction memory address written
TIMEOUT_CYCLES, 1024, maximum consecutive cycles without a transfer while loading (>=1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a load from IDLE or ERROR
src_valid  input  1  source word available
src_data  input  DATA_WIDTH  source word
src_ready  output  1  loader accepts a word this cycle
mem_address  output  ADDR_WIDTH  instruction memory write address
mem_data  output  DATA_WIDTH  instruction memory write data
mem_we  output  1  write strobe, active high, one cycle per word
core_enable  output  1  high = core (PC/pipeline) may run
done  output  1  image loaded and verified
error  output  1  checksum mismatch or timeout
words_loaded  output  $clog2(BOOT_WORDS+1)  data words written so far

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; word count, running sum and timeout counter cleared. Reset mid-load aborts immediately. No further mem_we pulses until a new start.
- All outputs are registered or decoded from the state register only. No combinational path from inputs to outputs.
- A transfer occurs on a rising edge where src_valid=1 and src_ready=1.
- States:
  - IDLE: src_ready=0. start moves to LOAD; count, sum and timer are cleared.
  - LOAD: src_ready=1.
    - Each transfer registers mem_address=BASE_ADDR+count (modulo 2^ADDR_WIDTH) and mem_data=src_data, and pulses mem_we high for exactly the following cycle.
    - Each transfer also sets sum=sum+src_data (modulo 2^DATA_WIDTH), increments count and clears the timer.
    - The transfer of word BOOT_WORDS-1 moves the state to CHECK.
    - Throughput is 1 word/cycle. Gaps in src_valid are allowed.
  - CHECK: src_ready=1. The next transfer is the checksum word and is not written to memory.
    - src_data==sum moves to RUN.
    - Otherwise the state moves to ERROR.
  - RUN: core_enable=1, done=1, src_ready=0. Terminal state until reset; start is ignored.
  - ERROR: error=1, core_enable=0, src_ready=0. start restarts LOAD (clears error, count, sum, timer).
- Timeout: in LOAD/CHECK the timer increments on every cycle without a transfer. Reaching TIMEOUT_CYCLES moves the state to ERROR on that edge. A transfer on the same edge wins (timer cleared, no error).
- start during LOAD/CHECK is ignored.
- words_loaded = count. It holds its value in RUN/ERROR.
- Ordering guarantee: the final mem_we pulse completes before core_enable rises. The checksum is accepted at the earliest one cycle after the last data word.
- mem_address/mem_data hold their last values when mem_we=0.

Test Plan:
- BOOT_WORDS=4, BASE_ADDR=0x100; start, then back-to-back words 1,2,3,4 and checksum 10 -> mem_we pulses at 0x100..0x103 with data 1..4 on four consecutive cycles; done=1, core_enable=1 after the checksum edge; words_loaded=4.
- Same image with checksum 11 -> error=1, core_enable=0, done=0; a later start with the correct image -> done=1, error=0.
- Words 0xFFFFFFFF,1,0,0, checksum 0 -> wrap-around sum accepted, done=1.
- TIMEOUT_CYCLES=8; two words, then src_valid low for 8 cycles -> error=1 exactly on the 8th idle edge. A word arriving on that edge instead -> no error.
- src_valid toggling 1,0,1,0 with start pulsed mid-load -> start ignored; each accepted word written once, addresses contiguous, no mem_we during gaps.
- reset asserted after the 2nd word -> all outputs 0 immediately. Further src_valid is not accepted until start; a new load writes from BASE_ADDR.
